// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous-SRAM responder.
// State encoding, inactive pin levels and the byte-to-word address helper.
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4
    } sram_state_e;

    localparam int         RAM_AW_DEF = 20;
    localparam logic [3:0] BE_N_NONE  = 4'hF;
    localparam logic [3:0] BE_N_ALL   = 4'h0;

    // Word index of a byte address; callers keep the low RAM_AW bits.
    function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/sram_responder.sv
// Turns one core-side request into a timed pin sequence on one 32-bit async SRAM bank.
// All pins are registered; the chip top level owns the tri-state buffer.
module sram_responder
    import sram_pkg::*;
#(
    parameter int RAM_AW     = RAM_AW_DEF,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_en,
    input  logic [3:0]        req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [3:0]        ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [31:0]       ram_data_out,
    output logic              ram_data_oe,
    input  logic [31:0]       ram_data_in
);

    if (READ_WAIT < 0 || READ_WAIT > 7 || WRITE_WAIT < 0 || WRITE_WAIT > 7 ||
        RAM_AW < 1 || RAM_AW > 29) begin : g_bad_params
        $error("sram_responder: wait parameters must be 0-7 and RAM_AW 1-29");
    end

    localparam logic [2:0] RD_CNT = 3'(READ_WAIT);
    localparam logic [2:0] WR_CNT = 3'(WRITE_WAIT);

    sram_state_e       state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [3:0]        be_n_act_q, be_n_act_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              data_oe_q, data_oe_d;
    logic [3:0]        be_n_q, be_n_d;
    logic [29:0]       widx;
    logic              addr_unused;

    assign widx        = word_index(req_addr);
    assign addr_unused = ^widx[29:RAM_AW];
    assign req_ready   = (state_q == IDLE) && !reset;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        be_n_act_d   = be_n_act_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_en && req_ready) begin
                    addr_d  = widx[RAM_AW-1:0];
                    wdata_d = req_wdata;
                    if (req_we != 4'h0) begin
                        be_n_act_d = ~req_we;
                        state_d    = WR_SETUP;
                        cnt_d      = 3'd0;
                    end else begin
                        be_n_act_d = BE_N_ALL;
                        state_d    = RD;
                        cnt_d      = RD_CNT;
                    end
                end
            end
            RD: begin
                // Sample the bus on the final strobe edge, respond from IDLE.
                if (cnt_q == 3'd0) begin
                    rdata_d      = ram_data_in;
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = WR_CNT;
            end
            WR_PULSE: begin
                if (cnt_q == 3'd0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WR_HOLD: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pins are decoded from the next state so they line up with the registered state.
    always_comb begin
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        data_oe_d = 1'b0;
        be_n_d    = BE_N_NONE;
        case (state_d)
            RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = be_n_act_d;
            end
            WR_SETUP, WR_HOLD: begin
                ce_n_d    = 1'b0;
                data_oe_d = 1'b1;
                be_n_d    = be_n_act_d;
            end
            WR_PULSE: begin
                ce_n_d    = 1'b0;
                we_n_d    = 1'b0;
                data_oe_d = 1'b1;
                be_n_d    = be_n_act_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            addr_q       <= '0;
            be_n_act_q   <= BE_N_NONE;
            wdata_q      <= 32'h0;
            rdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            data_oe_q    <= 1'b0;
            be_n_q       <= BE_N_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            be_n_act_q   <= be_n_act_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            data_oe_q    <= data_oe_d;
            be_n_q       <= be_n_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = rdata_q;
    assign ram_addr     = addr_q;
    assign ram_be_n     = be_n_q;
    assign ram_ce_n     = ce_n_q;
    assign ram_oe_n     = oe_n_q;
    assign ram_we_n     = we_n_q;
    assign ram_data_out = wdata_q;
    assign ram_data_oe  = data_oe_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: SRAM pin model, vector table, scoreboard queue and corner sequences.
// Two extra instances with READ_WAIT=0 and READ_WAIT=7 cover the latency extremes.
module tb_sram_responder;

    localparam int RW = 1;
    localparam int WW = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_en;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [19:0] ram_addr;
    logic [3:0]  ram_be_n;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic [31:0] ram_data_out;
    logic        ram_data_oe;
    logic [31:0] ram_data_in;

    // clock / reset
    always #5 clk = ~clk;

    sram_responder #(.RAM_AW(20), .READ_WAIT(RW), .WRITE_WAIT(WW)) u_dut (
        .clk(clk), .reset(reset), .req_en(req_en), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .ram_addr(ram_addr),
        .ram_be_n(ram_be_n), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
        .ram_we_n(ram_we_n), .ram_data_out(ram_data_out), .ram_data_oe(ram_data_oe),
        .ram_data_in(ram_data_in)
    );

    // latency-extreme instances (read-only traffic)
    logic        r0_en, r0_ready, r0_valid, r0_oe_n;
    logic [31:0] r0_addr, r0_rdata, r0_din;
    logic [19:0] r0_unused_addr;
    logic [3:0]  r0_unused_be;
    logic        r0_unused_ce, r0_unused_we, r0_unused_doe;
    logic [31:0] r0_unused_dout;
    logic        r7_en, r7_ready, r7_valid, r7_oe_n;
    logic [31:0] r7_addr, r7_rdata, r7_din;
    logic [19:0] r7_unused_addr;
    logic [3:0]  r7_unused_be;
    logic        r7_unused_ce, r7_unused_we, r7_unused_doe;
    logic [31:0] r7_unused_dout;

    assign r0_din = !r0_oe_n ? 32'h0BAD_F00D : 32'h0;
    assign r7_din = !r7_oe_n ? 32'h7777_ABCD : 32'h0;

    sram_responder #(.RAM_AW(20), .READ_WAIT(0), .WRITE_WAIT(1)) u_rw0 (
        .clk(clk), .reset(reset), .req_en(r0_en), .req_we(4'h0), .req_addr(r0_addr),
        .req_wdata(32'h0), .req_ready(r0_ready), .resp_valid(r0_valid), .resp_rdata(r0_rdata),
        .ram_addr(r0_unused_addr), .ram_be_n(r0_unused_be), .ram_ce_n(r0_unused_ce),
        .ram_oe_n(r0_oe_n), .ram_we_n(r0_unused_we), .ram_data_out(r0_unused_dout),
        .ram_data_oe(r0_unused_doe), .ram_data_in(r0_din)
    );

    sram_responder #(.RAM_AW(20), .READ_WAIT(7), .WRITE_WAIT(1)) u_rw7 (
        .clk(clk), .reset(reset), .req_en(r7_en), .req_we(4'h0), .req_addr(r7_addr),
        .req_wdata(32'h0), .req_ready(r7_ready), .resp_valid(r7_valid), .resp_rdata(r7_rdata),
        .ram_addr(r7_unused_addr), .ram_be_n(r7_unused_be), .ram_ce_n(r7_unused_ce),
        .ram_oe_n(r7_oe_n), .ram_we_n(r7_unused_we), .ram_data_out(r7_unused_dout),
        .ram_data_oe(r7_unused_doe), .ram_data_in(r7_din)
    );

    // SRAM pin model: drives the bus while selected and output-enabled, writes mid-pulse
    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    assign ram_data_in = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[7:0]] : 32'h0;

    always @(negedge clk) begin
        if (!ram_ce_n && !ram_we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!ram_be_n[b]) mem[ram_addr[7:0]][8*b +: 8] = ram_data_out[8*b +: 8];
            end
        end
    end

    // scoreboard
    int          n_checks = 0;
    int          n_pass = 0;
    int          contention = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (ram_data_oe === 1'b1 && ram_oe_n === 1'b0) contention++;
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: resp_valid=1 rdata=%h with nothing outstanding", resp_rdata);
            end else begin
                chk("resp_rdata", resp_rdata, exp_q.pop_front());
            end
        end
    end

    // driver: call at a negedge; returns at the negedge of the resp_valid cycle
    task automatic do_req(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [19:0] exp_addr, input logic [3:0] exp_be_n,
                          input logic [31:0] exp_rdata, input bit poke);
        int          n;
        int          bad;
        int          exp_lat;
        logic [31:0] oe_m, we_m, doe_m, exp_oe, exp_we, exp_doe;
        exp_lat = (we != 4'h0) ? WW + 4 : RW + 2;
        exp_oe  = (we != 4'h0) ? 32'h0 : ((32'd1 << (RW + 1)) - 1) << 1;
        exp_we  = (we != 4'h0) ? ((32'd1 << (WW + 1)) - 1) << 2 : 32'h0;
        exp_doe = (we != 4'h0) ? ((32'd1 << (WW + 3)) - 1) << 1 : 32'h0;
        req_en = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        chk("req_ready_at_drive", {31'h0, req_ready}, 32'h1);
        exp_q.push_back(exp_rdata);
        if (we != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (we[b]) ref_mem[exp_addr[7:0]][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            last_rd = exp_rdata;
        end
        @(posedge clk);
        @(negedge clk);
        req_en = 1'b0; req_we = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
        n = 1; bad = 0; oe_m = 0; we_m = 0; doe_m = 0;
        while (resp_valid !== 1'b1 && n < 31) begin
            oe_m[n]  = !ram_oe_n;
            we_m[n]  = !ram_we_n;
            doe_m[n] = ram_data_oe;
            if (ram_addr !== exp_addr || ram_be_n !== exp_be_n || ram_ce_n !== 1'b0) bad++;
            if (we != 4'h0 && ram_data_out !== wdata) bad++;
            if (poke && n == 1) begin
                chk("ready_low_when_busy", {31'h0, req_ready}, 32'h0);
                req_en = 1'b1; req_we = 4'hF; req_addr = 32'h0000_0300; req_wdata = 32'hFFFF_FFFF;
            end
            if (poke && n == 2) req_en = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("latency", n, exp_lat);
        chk("oe_window", oe_m, exp_oe);
        chk("we_window", we_m, exp_we);
        chk("data_oe_window", doe_m, exp_doe);
        chk("addr_be_ce_stable", bad, 0);
    endtask

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [19:0] exp_addr;
        logic [3:0]  exp_be_n;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; req_en = 1'b0; req_we = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
        r0_en = 1'b0; r0_addr = 32'h0; r7_en = 1'b0; r7_addr = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = (i >= 32 && i < 64) ? i * 32'h0101_0101 : 32'h0;
        mem[1] = 32'hA5A5_A5A5; mem[2] = 32'h1122_3344; mem[4] = 32'hDEAD_BEEF;
        mem[100] = 32'h5555_5555;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        vecs[0] = '{4'h0, 32'h0000_0010, 32'h0,         20'h4,     4'h0, 32'hDEAD_BEEF};
        vecs[1] = '{4'h2, 32'h0000_0008, 32'h0000_AB00, 20'h2,     4'hD, 32'hDEAD_BEEF};
        vecs[2] = '{4'h0, 32'h0000_000B, 32'h0,         20'h2,     4'h0, 32'h1122_AB44};
        vecs[3] = '{4'hF, 32'h0000_0040, 32'hCAFE_F00D, 20'h10,    4'h0, 32'h1122_AB44};
        vecs[4] = '{4'h0, 32'h0000_0040, 32'h0,         20'h10,    4'h0, 32'hCAFE_F00D};
        vecs[5] = '{4'h9, 32'hFFC0_0004, 32'h0102_0304, 20'h00001, 4'h6, 32'hCAFE_F00D};
        vecs[6] = '{4'h0, 32'h0000_0004, 32'h0,         20'h1,     4'h0, 32'h01A5_A504};

        // reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", {31'h0, req_ready}, 32'h0);
        chk("pins_in_reset", {23'h0, ram_ce_n, ram_oe_n, ram_we_n, ram_be_n, ram_data_oe, resp_valid}, 32'h1FC);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        chk("pins_idle", {23'h0, ram_ce_n, ram_oe_n, ram_we_n, ram_be_n, ram_data_oe, resp_valid}, 32'h1FC);
        chk("addr_reset", {12'h0, ram_addr}, 32'h0);
        chk("data_out_reset", ram_data_out, 32'h0);
        chk("rdata_reset", resp_rdata, 32'h0);

        // vector table
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_addr,
                   vecs[i].exp_be_n, vecs[i].exp_rdata, 1'b0);
        end
        chk("sram_word2_byte1", mem[2], 32'h1122_AB44);

        // back-to-back: write issued in the read's resp_valid cycle
        @(negedge clk);
        do_req(4'h0, 32'h0000_0040, 32'h0, 20'h10, 4'h0, 32'hCAFE_F00D, 1'b0);
        do_req(4'hF, 32'h0000_0044, 32'h5A5A_0001, 20'h11, 4'h0, 32'hCAFE_F00D, 1'b0);
        do_req(4'h0, 32'h0000_0044, 32'h0, 20'h11, 4'h0, 32'h5A5A_0001, 1'b0);

        // request pulsed while busy is dropped
        @(negedge clk);
        do_req(4'h0, 32'h0000_0010, 32'h0, 20'h4, 4'h0, ref_mem[4], 1'b1);
        repeat (8) @(negedge clk);
        chk("poke_not_written", mem[8'hC0], 32'h0);

        // random traffic against the reference memory
        for (int k = 0; k < 12; k++) begin
            logic [3:0]  we;
            logic [7:0]  word;
            logic [31:0] exp;
            we   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            word = 8'($urandom_range(32, 63));
            exp  = (we != 4'h0) ? last_rd : ref_mem[word];
            @(negedge clk);
            do_req(we, {22'h0, word, 2'($urandom_range(0, 3))}, $urandom, {12'h0, word},
                   (we != 4'h0) ? ~we : 4'h0, exp, 1'b0);
        end

        // reset during the write pulse
        @(negedge clk);
        req_en = 1'b1; req_we = 4'hF; req_addr = 32'h0000_0190; req_wdata = 32'h1357_9BDF;
        chk("ready_before_abort", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_en = 1'b0;
        @(negedge clk);
        chk("we_n_low_in_pulse", {31'h0, ram_we_n}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("pins_after_abort", {23'h0, ram_ce_n, ram_oe_n, ram_we_n, ram_be_n, ram_data_oe, resp_valid}, 32'h1FC);
        chk("ready_during_abort", {31'h0, req_ready}, 32'h0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        do_req(4'h0, 32'h0000_0010, 32'h0, 20'h4, 4'h0, ref_mem[4], 1'b0);

        // READ_WAIT = 0
        @(negedge clk);
        r0_en = 1'b1; r0_addr = 32'h0000_0020;
        chk("rw0_ready", {31'h0, r0_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        r0_en = 1'b0;
        n = 1;
        while (r0_valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        chk("rw0_latency", n, 2);
        chk("rw0_rdata", r0_rdata, 32'h0BAD_F00D);

        // READ_WAIT = 7
        @(negedge clk);
        r7_en = 1'b1; r7_addr = 32'h0000_0024;
        chk("rw7_ready", {31'h0, r7_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        r7_en = 1'b0;
        n = 1;
        while (r7_valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        chk("rw7_latency", n, 9);
        chk("rw7_rdata", r7_rdata, 32'h7777_ABCD);

        repeat (3) @(negedge clk);
        chk("no_bus_contention", contention, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
